// File: rtl/sound_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sound_pkg
// Brief   : Shared constants, step-decode masks and types for the APU frame
//           sequencer and its trigger stretchers.
// Rev     : 1.0  initial release
// ============================================================================
package sound_pkg;

    localparam int FS_STEPS = 8;
    localparam int STEP_W   = $clog2(FS_STEPS);

    // Bit n set means the strobe fires when frame step n wraps.
    localparam logic [FS_STEPS-1:0] LEN_STEP_MASK   = 8'b0101_0101;
    localparam logic [FS_STEPS-1:0] SWEEP_STEP_MASK = 8'b0100_0100;
    localparam logic [FS_STEPS-1:0] ENV_STEP_MASK   = 8'b1000_0000;

    localparam int CH1 = 0;
    localparam int CH2 = 1;
    localparam int CH3 = 2;
    localparam int CH4 = 3;

    typedef logic [3:0] ch_vec_t;

    typedef enum logic [0:0] {
        TRIG_IDLE  = 1'b0,
        TRIG_PULSE = 1'b1
    } trig_state_t;

    function automatic logic step_hit(input logic [FS_STEPS-1:0] mask,
                                      input logic [STEP_W-1:0]   s);
        return mask[s];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sound_frame_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : sound_frame_seq_if
// Brief   : Register-file / channel side bundle of the frame sequencer.
// Rev     : 1.0  initial release
// ============================================================================
interface sound_frame_seq_if;
    import sound_pkg::*;

    logic              master_en;
    ch_vec_t           trig_req;
    ch_vec_t           trig_ack;
    ch_vec_t           start;
    logic              len_tick;
    logic              sweep_tick;
    logic              env_tick;
    logic [STEP_W-1:0] step;

    modport master (
        output master_en, trig_req,
        input  trig_ack, start, len_tick, sweep_tick, env_tick, step
    );

    modport slave (
        input  master_en, trig_req,
        output trig_ack, start, len_tick, sweep_tick, env_tick, step
    );

endinterface
`default_nettype wire

// File: rtl/sound_trig_stretch.sv
`default_nettype none
// ============================================================================
// Module  : sound_trig_stretch
// Brief   : One channel's trigger FSM: a request yields a one-cycle ack and a
//           START_LEN-cycle start pulse; a retrigger reloads without a gap.
// Rev     : 1.0  initial release
// ============================================================================
module sound_trig_stretch
    import sound_pkg::*;
#(
    parameter int START_LEN = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic en,
    input  wire logic req,
    output logic      ack,
    output logic      start
);

    localparam int             CNT_W = 4;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(START_LEN);

    trig_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ack_q;
    logic             start_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TRIG_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            start_q <= 1'b0;
        end else if (!en) begin
            // Powering the APU off truncates any pulse in flight.
            state_q <= TRIG_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            ack_q <= req;
            if (req) begin
                state_q <= TRIG_PULSE;
                cnt_q   <= LOAD;
                start_q <= 1'b1;
            end else begin
                case (state_q)
                    TRIG_PULSE: begin
                        if (cnt_q <= 1) begin
                            state_q <= TRIG_IDLE;
                            cnt_q   <= '0;
                            start_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        state_q <= TRIG_IDLE;
                        start_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ack   = ack_q;
    assign start = start_q;

endmodule
`default_nettype wire

// File: rtl/sound_frame_seq.sv
`default_nettype none
// ============================================================================
// Module  : sound_frame_seq
// Brief   : APU frame sequencer (512 Hz steps -> len/sweep/env strobes) and
//           per-channel trigger scheduling. Define SOUND_FRAME_SEQ_EXT_DIV_EN
//           to step on falling edges of div_bit instead of the CLK_DIV counter.
// Rev     : 1.0  initial release
// ============================================================================
module sound_frame_seq
    import sound_pkg::*;
#(
    parameter int CLK_DIV   = 8192,
    parameter int START_LEN = 4
) (
    input  wire logic clk,
    input  wire logic rst,
`ifdef SOUND_FRAME_SEQ_EXT_DIV_EN
    input  wire logic div_bit,
`endif
    sound_frame_seq_if.slave bus
);

    logic w_frame_evt;

`ifdef SOUND_FRAME_SEQ_EXT_DIV_EN
    logic div_bit_q, div_bit_d;
    logic div_prev_q, div_prev_d;

    always_comb begin
        div_bit_d   = div_bit;
        div_prev_d  = div_bit_q;
        w_frame_evt = bus.master_en && div_prev_q && !div_bit_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_bit_q  <= 1'b0;
            div_prev_q <= 1'b0;
        end else begin
            div_bit_q  <= div_bit_d;
            div_prev_q <= div_prev_d;
        end
    end
`else
    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

    always_comb begin
        w_frame_evt = bus.master_en && (div_cnt_q == DIV_LAST);
        div_cnt_d   = '0;
        if (bus.master_en && !w_frame_evt) begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end
`endif

    logic [STEP_W-1:0] step_q, step_d;
    logic              len_q, len_d;
    logic              sweep_q, sweep_d;
    logic              env_q, env_d;

    // Strobes decode the step that is wrapping, not the incremented one.
    always_comb begin
        step_d  = '0;
        len_d   = 1'b0;
        sweep_d = 1'b0;
        env_d   = 1'b0;
        if (bus.master_en) begin
            step_d = step_q;
            if (w_frame_evt) begin
                step_d  = step_q + 1'b1;
                len_d   = step_hit(LEN_STEP_MASK, step_q);
                sweep_d = step_hit(SWEEP_STEP_MASK, step_q);
                env_d   = step_hit(ENV_STEP_MASK, step_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q  <= '0;
            len_q   <= 1'b0;
            sweep_q <= 1'b0;
            env_q   <= 1'b0;
        end else begin
            step_q  <= step_d;
            len_q   <= len_d;
            sweep_q <= sweep_d;
            env_q   <= env_d;
        end
    end

    assign bus.step       = step_q;
    assign bus.len_tick   = len_q;
    assign bus.sweep_tick = sweep_q;
    assign bus.env_tick   = env_q;

    ch_vec_t w_ack;
    ch_vec_t w_start;

    for (genvar i = CH1; i <= CH4; i++) begin : g_ch
        sound_trig_stretch #(
            .START_LEN (START_LEN)
        ) u_stretch (
            .clk   (clk),
            .rst   (rst),
            .en    (bus.master_en),
            .req   (bus.trig_req[i]),
            .ack   (w_ack[i]),
            .start (w_start[i])
        );
    end

    assign bus.trig_ack = w_ack;
    assign bus.start    = w_start;

endmodule
`default_nettype wire

// File: tb/tb_sound_frame_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_sound_frame_seq
// Brief   : Self-checking bench for sound_frame_seq (CLK_DIV=16, START_LEN=4).
// Rev     : 1.0  initial release
// ============================================================================
module tb_sound_frame_seq;

    localparam int CLK_DIV   = 16;
    localparam int START_LEN = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    sound_frame_seq_if bus ();

`ifdef SOUND_FRAME_SEQ_EXT_DIV_EN
    logic div_bit = 1'b0;
    sound_frame_seq #(.CLK_DIV(CLK_DIV), .START_LEN(START_LEN)) dut (
        .clk(clk), .rst(rst), .div_bit(div_bit), .bus(bus));
`else
    sound_frame_seq #(.CLK_DIV(CLK_DIV), .START_LEN(START_LEN)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    // Reference model: counts enabled edges and remaining pulse cycles.
    int         m_en_cnt;
    int         m_rem [4];
    logic [3:0] m_ack, m_start;
    logic       m_len, m_sweep, m_env;
    logic [2:0] m_step;

    task automatic model_reset();
        m_en_cnt = 0;
        for (int c = 0; c < 4; c++) m_rem[c] = 0;
        m_ack = '0; m_start = '0;
        m_len = 1'b0; m_sweep = 1'b0; m_env = 1'b0;
        m_step = '0;
    endtask

    task automatic model_edge(input logic en, input logic [3:0] req);
        int k;
        m_ack = '0; m_start = '0;
        m_len = 1'b0; m_sweep = 1'b0; m_env = 1'b0;
        if (!en) begin
            model_reset();
            return;
        end
        m_en_cnt++;
        if (m_en_cnt % CLK_DIV == 0) begin
            k       = (m_en_cnt / CLK_DIV - 1) % 8;
            m_len   = (k % 2 == 0);
            m_sweep = (k == 2 || k == 6);
            m_env   = (k == 7);
        end
        m_step = 3'((m_en_cnt / CLK_DIV) % 8);
        for (int c = 0; c < 4; c++) begin
            if (req[c]) begin
                m_ack[c] = 1'b1;
                m_rem[c] = START_LEN;
            end else if (m_rem[c] > 0) begin
                m_rem[c]--;
            end
            m_start[c] = (m_rem[c] > 0);
        end
    endtask

    function automatic logic [13:0] dut_vec();
        return {bus.trig_ack, bus.start, bus.len_tick, bus.sweep_tick,
                bus.env_tick, bus.step};
    endfunction

    function automatic logic [13:0] model_vec();
        return {m_ack, m_start, m_len, m_sweep, m_env, m_step};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mcheck(input string name);
        check(name, 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic tick(input logic en, input logic [3:0] req);
        bus.master_en = en;
        bus.trig_req  = req;
        @(posedge clk);
        model_edge(en, req);
        #1;
    endtask

    task automatic do_reset();
        bus.master_en = 1'b0;
        bus.trig_req  = '0;
        rst = 1'b1;
        model_reset();
        #1;
        check("reset_async", 32'(dut_vec()), 32'd0);
        @(posedge clk);
        #1;
        check("reset_hold", 32'(dut_vec()), 32'd0);
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic       en;
        logic [3:0] req;
        logic [3:0] ack;
        logic [3:0] start;
        logic [2:0] strb;
        logic [2:0] step;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [3:0]  r;
        logic [13:0] ev;
        logic        e_len, e_sweep, e_env;

        bus.master_en = 1'b0;
        bus.trig_req  = '0;
        #2;
        do_reset();

        // Single trigger, idle, retrigger two cycles apart, then power-off.
        tbl[0]  = '{1'b1, 4'b0001, 4'b0001, 4'b0001, 3'b000, 3'd0};
        tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 4'b0001, 3'b000, 3'd0};
        tbl[2]  = '{1'b1, 4'b0000, 4'b0000, 4'b0001, 3'b000, 3'd0};
        tbl[3]  = '{1'b1, 4'b0000, 4'b0000, 4'b0001, 3'b000, 3'd0};
        tbl[4]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 3'b000, 3'd0};
        tbl[5]  = '{1'b1, 4'b0010, 4'b0010, 4'b0010, 3'b000, 3'd0};
        tbl[6]  = '{1'b1, 4'b0000, 4'b0000, 4'b0010, 3'b000, 3'd0};
        tbl[7]  = '{1'b1, 4'b0010, 4'b0010, 4'b0010, 3'b000, 3'd0};
        tbl[8]  = '{1'b1, 4'b0000, 4'b0000, 4'b0010, 3'b000, 3'd0};
        tbl[9]  = '{1'b1, 4'b0000, 4'b0000, 4'b0010, 3'b000, 3'd0};
        tbl[10] = '{1'b1, 4'b0000, 4'b0000, 4'b0010, 3'b000, 3'd0};
        tbl[11] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 3'b000, 3'd0};
        tbl[12] = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 3'b000, 3'd0};

        for (int i = 0; i < 13; i++) begin
            tick(tbl[i].en, tbl[i].req);
            check($sformatf("tbl%0d", i), 32'(dut_vec()),
                  32'({tbl[i].ack, tbl[i].start, tbl[i].strb, tbl[i].step}));
            mcheck($sformatf("tbl%0d_model", i));
        end

        // Full 8-step frame with a four-channel trigger on the step-6 wrap.
        do_reset();
        for (int i = 0; i < 128; i++) begin
            r       = (i == 111) ? 4'b1111 : 4'b0000;
            tick(1'b1, r);
            e_len   = (i == 15 || i == 47 || i == 79 || i == 111);
            e_sweep = (i == 47 || i == 111);
            e_env   = (i == 127);
            ev = {(i == 111) ? 4'b1111 : 4'b0000,
                  (i >= 111 && i <= 114) ? 4'b1111 : 4'b0000,
                  e_len, e_sweep, e_env, 3'(((i + 1) / 16) % 8)};
            check($sformatf("frame%0d", i), 32'(dut_vec()), 32'(ev));
        end
        check("step_wrap_to_0", 32'(bus.step), 32'd0);

        // Power-off at step 5 in the middle of a start pulse.
        do_reset();
        for (int i = 0; i < 80; i++) begin
            tick(1'b1, 4'b0000);
            mcheck("pre_off");
        end
        tick(1'b1, 4'b0100);
        tick(1'b1, 4'b0000);
        check("pulse_on", 32'({bus.start, bus.step}), 32'({4'b0100, 3'd5}));
        tick(1'b0, 4'b0000);
        check("en_off", 32'(dut_vec()), 32'd0);
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 4'b0000);
            check($sformatf("reen%0d", i), 32'({bus.len_tick, bus.start}),
                  (i == 15) ? 32'h10 : 32'h0);
            mcheck("reen_model");
        end
        check("reen_step", 32'(bus.step), 32'd1);

        // Asynchronous reset at step 6 during a pulse.
        do_reset();
        for (int i = 0; i < 96; i++) tick(1'b1, 4'b0000);
        tick(1'b1, 4'b1000);
        check("pre_rst", 32'({bus.start, bus.step}), 32'({4'b1000, 3'd6}));
        #1;
        rst = 1'b1;
        #1;
        check("rst_async", 32'(dut_vec()), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 4'b0000);
            mcheck("resume");
        end
        check("resume_len", 32'({bus.len_tick, bus.step}), 32'({1'b1, 3'd1}));

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            r = '0;
            for (int c = 0; c < 4; c++) r[c] = ($urandom % 6 == 0);
            tick(($urandom % 60) != 0, r);
            mcheck("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
